// File: rtl/cgp_eval_pkg.sv
// Shared constants, state encoding and vec field offsets for the CGP adder
// fitness evaluator and its candidate harness.
package cgp_eval_pkg;

  localparam int WIDTH = 3;
  localparam int N_IN  = 2*WIDTH + 1;
  localparam int N_OUT = WIDTH + 1;
  localparam int CNT_W = N_IN + $clog2(N_OUT) + 1;

  // vec bit-field offsets: a in [A_LSB +: WIDTH], b in [B_LSB +: WIDTH], cin at CIN_BIT
  localparam int A_LSB   = 0;
  localparam int B_LSB   = WIDTH;
  localparam int CIN_BIT = 2*WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } eval_state_e;

  // Number of set bits in a candidate/golden difference, sized for the accumulator
  function automatic logic [CNT_W-1:0] popcnt(input logic [N_OUT-1:0] x);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_OUT; i++) c = c + CNT_W'(x[i]);
    return c;
  endfunction

endpackage

// File: rtl/cgp_golden_add.sv
// Reference WIDTH-bit adder with carry-in; output is {cout, sum}.
module cgp_golden_add #(
  parameter int W = 3
) (
  input  logic [2*W:0] vec,
  output logic [W:0]   gold
);

  // a + b + cin evaluated at W+1 bits so the carry lands in the top bit
  always_comb begin
    gold = {1'b0, vec[W-1:0]} + {1'b0, vec[2*W-1:W]} + {{W{1'b0}}, vec[2*W]};
  end

endmodule

// File: rtl/cgp_fitness_eval.sv
// Exhaustive fitness evaluator for evolved 3-bit adder candidates.
// Sweeps every input vector through the candidate, counts mismatches vs. the
// built-in golden adder and publishes the count as fitness.
// Build option: FITNESS_HAMMING_EN -> weight each vector by the number of
// wrong output bits instead of a single any-bit-wrong flag.
module cgp_fitness_eval
  import cgp_eval_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  vec,
  input  logic [N_OUT-1:0] cand_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic             perfect
);

  localparam logic [N_IN-1:0] VEC_LAST = '1;

  eval_state_e      state_q, state_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             perf_q, perf_d;

  logic [N_OUT-1:0] gold;
  logic [N_OUT-1:0] diff;
  logic [CNT_W-1:0] weight;

  cgp_golden_add #(.W(WIDTH)) u_gold (
    .vec  (vec_q),
    .gold (gold)
  );

  // Per-vector mismatch weight; the candidate path is purely combinational from vec_q
  always_comb begin
    diff = cand_out ^ gold;
`ifdef FITNESS_HAMMING_EN
    weight = popcnt(diff);
`else
    weight = CNT_W'(|diff);
`endif
  end

  // Next-state: sweep control, accumulation and result publication.
  // The result registers are loaded on the RUN->FIN edge so done, busy drop
  // and err_count all appear in the single FIN cycle.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    acc_d   = acc_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    perf_d  = perf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          vec_d   = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          vec_d   = '0;
          busy_d  = 1'b0;
        end else begin
          acc_d = acc_q + weight;
          if (vec_q == VEC_LAST) begin
            state_d = ST_FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = acc_d;
            perf_d  = (acc_d == '0);
          end else begin
            vec_d = vec_q + N_IN'(1);
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      acc_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      perf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      perf_q  <= perf_d;
    end
  end

  assign vec       = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_count = err_q;
  assign perfect   = perf_q;

endmodule

// File: tb/tb_cgp_fitness_eval.sv
// Self-checking bench for cgp_fitness_eval: fixed fault candidates plus
// random bit-flip candidates scored against an arithmetic reference model.
module tb_cgp_fitness_eval;
  import cgp_eval_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [N_IN-1:0]  vec;
  logic [N_OUT-1:0] cand_out;
  logic             busy, done, perfect;
  logic [CNT_W-1:0] err_count;

  logic [N_OUT-1:0] lib_gold;
  logic [N_OUT-1:0] arith_gold;
  logic [N_OUT-1:0] msk [128];
  int               mode = 0;
  int               n_chk = 0;
  int               n_fail = 0;

  always #5 clk = ~clk;

  cgp_fitness_eval dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .vec       (vec),
    .cand_out  (cand_out),
    .busy      (busy),
    .done      (done),
    .err_count (err_count),
    .perfect   (perfect)
  );

  // Reference candidate from the library adder
  cgp_golden_add #(.W(WIDTH)) u_ref (.vec(vec), .gold(lib_gold));

  // Candidate netlist under evaluation: mode 0 is the library adder, others
  // are faults applied to a sum computed directly in the bench
  always_comb begin
    arith_gold = 4'(vec[2:0]) + 4'(vec[5:3]) + 4'(vec[6]);
    case (mode)
      0:       cand_out = lib_gold;
      1:       cand_out = arith_gold & 4'h7;
      2:       cand_out = arith_gold ^ 4'hf;
      3:       cand_out = arith_gold ^ 4'h3;
      default: cand_out = arith_gold ^ msk[vec];
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected fitness from the adder truth table
  function automatic int model_err(input int m);
    int tot = 0;
    for (int v = 0; v < 128; v++) begin
      int a, b, c, g, cd, w;
      a = v % 8; b = (v / 8) % 8; c = v / 64;
      g = a + b + c;
      case (m)
        0:       cd = g;
        1:       cd = g % 8;
        2:       cd = g ^ 15;
        3:       cd = g ^ 3;
        default: cd = g ^ int'(msk[v]);
      endcase
`ifdef FITNESS_HAMMING_EN
      w = $countones(cd ^ g);
`else
      w = (cd != g) ? 1 : 0;
`endif
      tot += w;
    end
    return tot;
  endfunction

  task automatic rand_mask();
    for (int v = 0; v < 128; v++) msk[v] = 4'($urandom_range(0, 15));
  endtask

  // One full evaluation; checks latency, vec sweep, busy/done and result
  task automatic run_eval(input int m, input string tag, input logic with_abort);
    int cyc, vbad, exp;
    mode = m;
    exp  = model_err(m);
    @(negedge clk); start = 1'b1; abort = with_abort;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    cyc = 1; vbad = 0;
    chk({tag, "_busy_up"}, busy, 1);
    while (!done && cyc < 300) begin
      if (cyc <= 128 && (vec != N_IN'(cyc - 1) || !busy)) vbad++;
      @(negedge clk); cyc++;
    end
    chk({tag, "_sweep"}, vbad, 0);
    chk({tag, "_latency"}, cyc, 129);
    chk({tag, "_busy_dn"}, busy, 0);
    chk({tag, "_err"}, err_count, exp);
    chk({tag, "_perfect"}, perfect, exp == 0);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, done, 0);
    chk({tag, "_vec_hold"}, vec, 127);
  endtask

  task automatic wait_vec(input int target, input string tag);
    int n = 0;
    while (vec != N_IN'(target) && n < 300) begin @(negedge clk); n++; end
    chk({tag, "_reach"}, vec, target);
  endtask

  initial begin
    int t_done [$];
    int cyc, ndone, exp4;

    // reset state
    #1;
    chk("rst_vec", vec, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_count, 0);
    chk("rst_perfect", perfect, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_eval(0, "golden", 1'b0);
    run_eval(1, "cout_sa0", 1'b0);
`ifdef FITNESS_HAMMING_EN
    chk("cout_sa0_abs", err_count, 64);
`else
    chk("cout_sa0_abs", err_count, 64);
`endif
    run_eval(2, "all_inv", 1'b0);
    run_eval(3, "sum01_inv", 1'b1);   // start with abort in IDLE: start wins
    for (int r = 0; r < 3; r++) begin
      rand_mask();
      run_eval(4, "rand", 1'b0);
    end

    // abort mid-run keeps the previous (perfect) result
    run_eval(0, "golden2", 1'b0);
    mode = 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_vec(40, "abort");
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_vec", vec, 0);
    ndone = 0;
    repeat (140) begin @(negedge clk); if (done) ndone++; end
    chk("abort_nodone", ndone, 0);
    chk("abort_err", err_count, 0);
    chk("abort_perfect", perfect, 1);
    run_eval(1, "after_abort", 1'b0);

    // asynchronous reset mid-run
    mode = 2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_vec(60, "rst");
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_vec", vec, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err_count, 0);
    chk("midrst_perfect", perfect, 0);
    @(negedge clk); rst_n = 1'b1;
    run_eval(2, "after_rst", 1'b0);

    // start held high: one evaluation per 130 cycles
    rand_mask();
    mode = 4;
    exp4 = model_err(4);
    @(negedge clk); start = 1'b1;
    cyc = 0;
    while (t_done.size() < 3 && cyc < 600) begin
      @(negedge clk); cyc++;
      if (done) begin
        t_done.push_back(cyc);
        chk("held_err", err_count, exp4);
      end
    end
    start = 1'b0;
    chk("held_count", t_done.size(), 3);
    if (t_done.size() == 3) begin
      chk("held_gap1", t_done[1] - t_done[0], 130);
      chk("held_gap2", t_done[2] - t_done[1], 130);
    end
    repeat (3) @(negedge clk);
    chk("held_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
